// File: rtl/ccff_load_ctrl.sv
// ccff_load_ctrl: loads one tile's configuration chain by serialising bitstream words LSB-first onto ccff_head.
// Define CCFF_VERIFY_EN to add a recirculating readback pass that CRC-checks the chain contents.
module ccff_load_ctrl #(
    parameter int CHAIN_LEN = 256,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  bit_count
);
    localparam int WB_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);
`ifdef CCFF_VERIFY_EN
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, VERIFY, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE} state_t;
`endif
    state_t            state_q;
    logic              word_ready_q, shift_en_q, head_q, busy_q, done_q;
    logic [CNT_W-1:0]  bit_count_q;
    logic [WB_W-1:0]   wbit_q;
    logic [WORD_W-1:0] shreg_q;
`ifdef CCFF_VERIFY_EN
    logic [7:0]        crc_load_q, crc_tail_q, crc_load_d, crc_tail_d;
    logic [CNT_W-1:0]  v_q;
    logic              err_q;
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction
    assign crc_load_d = crc8(crc_load_q, head_q);
    assign crc_tail_d = crc8(crc_tail_q, ccff_tail);
    // During readback the tail is fed straight back so the chain ends where it started.
    assign ccff_head  = (state_q == VERIFY) ? ccff_tail : head_q;
    assign err        = err_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign ccff_head   = head_q;
    assign err         = 1'b0;
`endif
    assign word_ready = word_ready_q;
    assign shift_en   = shift_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign bit_count  = bit_count_q;

    always_ff @(posedge prog_clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            word_ready_q <= 1'b0;
            shift_en_q   <= 1'b0;
            head_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bit_count_q  <= '0;
            wbit_q       <= '0;
            shreg_q      <= '0;
`ifdef CCFF_VERIFY_EN
            crc_load_q   <= '0;
            crc_tail_q   <= '0;
            v_q          <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q      <= LOAD;
                    word_ready_q <= 1'b1;
                    busy_q       <= 1'b1;
                    bit_count_q  <= '0;
`ifdef CCFF_VERIFY_EN
                    crc_load_q   <= '0;
                    err_q        <= 1'b0;
`endif
                end
                LOAD: if (word_valid) begin
                    state_q      <= SHIFT;
                    word_ready_q <= 1'b0;
                    shift_en_q   <= 1'b1;
                    head_q       <= word_data[0];
                    shreg_q      <= word_data >> 1;
                    wbit_q       <= '0;
                end
                SHIFT: begin
                    bit_count_q <= bit_count_q + 1'b1;
                    wbit_q      <= wbit_q + 1'b1;
`ifdef CCFF_VERIFY_EN
                    crc_load_q  <= crc_load_d;
`endif
                    // Chain exhaustion wins: leftover bits of the final word are dropped.
                    if (bit_count_q == LAST_BIT) begin
                        head_q     <= 1'b0;
`ifdef CCFF_VERIFY_EN
                        state_q    <= VERIFY;
                        v_q        <= '0;
                        crc_tail_q <= '0;
`else
                        state_q    <= DONE;
                        shift_en_q <= 1'b0;
                        done_q     <= 1'b1;
`endif
                    end else if (wbit_q == LAST_WBIT) begin
                        state_q      <= LOAD;
                        shift_en_q   <= 1'b0;
                        word_ready_q <= 1'b1;
                        head_q       <= 1'b0;
                    end else begin
                        head_q  <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                    end
                end
`ifdef CCFF_VERIFY_EN
                VERIFY: begin
                    crc_tail_q <= crc_tail_d;
                    v_q        <= v_q + 1'b1;
                    if (v_q == LAST_BIT) begin
                        state_q    <= DONE;
                        shift_en_q <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= crc_load_q != crc_tail_d;
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
